// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU operation blocks and their result capture stage.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef struct packed {
        logic zero;
        logic negativo;
        logic carry;
        logic overflow;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        alu_flags_t           flags;
    } alu_entry_t;

    // Accumulate flags; a clear in the same cycle keeps only the new flags.
    function automatic alu_flags_t merge_flags(alu_flags_t acc, alu_flags_t f, logic clr);
        return clr ? f : alu_flags_t'(acc | f);
    endfunction

endpackage

// File: rtl/alu_capture_fifo_mem.sv
// Entry storage for the capture FIFO: synchronous write, asynchronous read, no reset.
module alu_capture_fifo_mem #(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_capture.sv
// Show-ahead capture FIFO for ALU results with sticky flags.
// Optional drop counter enabled by defining ALU_CAPTURE_DROP_CNT_EN.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           y_in,
    input  logic                       zero_in,
    input  logic                       negativo_in,
    input  logic                       carry_in,
    input  logic                       overflow_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y_out,
    output logic                       zero_out,
    output logic                       negativo_out,
    output logic                       carry_out,
    output logic                       overflow_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    input  logic                       clear_sticky,
`ifdef ALU_CAPTURE_DROP_CNT_EN
    output logic [7:0]                 drop_count,
`endif
    output logic [3:0]                 sticky_flags
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = WIDTH + 4;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    alu_flags_t         flags_in;
    alu_flags_t         head_flags;
    alu_flags_t         sticky;
    logic [ENTRY_W-1:0] head;

    assign flags_in.zero     = zero_in;
    assign flags_in.negativo = negativo_in;
    assign flags_in.carry    = carry_in;
    assign flags_in.overflow = overflow_in;

    // Handshake depends only on the registered count.
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    alu_capture_fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({y_in, flags_in}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Outputs read zero while empty so stale storage never leaks out.
    assign head_flags   = alu_flags_t'(head[3:0]);
    assign y_out        = empty ? '0 : head[ENTRY_W-1:4];
    assign zero_out     = !empty && head_flags.zero;
    assign negativo_out = !empty && head_flags.negativo;
    assign carry_out    = !empty && head_flags.carry;
    assign overflow_out = !empty && head_flags.overflow;
    assign sticky_flags = sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push) begin
                sticky <= merge_flags(sticky, flags_in, clear_sticky);
            end else if (clear_sticky) begin
                sticky <= '0;
            end
        end
    end

`ifdef ALU_CAPTURE_DROP_CNT_EN
    // Counts cycles a producer was refused; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (clear_sticky) begin
            drop_count <= '0;
        end else if (in_valid && !in_ready && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture; covers drop_count when ALU_CAPTURE_DROP_CNT_EN is defined.
module tb_alu_result_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y_in;
    logic [3:0] flags_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y_out;
    logic       zero_out;
    logic       negativo_out;
    logic       carry_out;
    logic       overflow_out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       clear_sticky;
    logic [3:0] sticky_flags;
`ifdef ALU_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_entry;

    always #5 clk = ~clk;

    alu_result_capture #(.WIDTH(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .y_in         (y_in),
        .zero_in      (flags_in[3]),
        .negativo_in  (flags_in[2]),
        .carry_in     (flags_in[1]),
        .overflow_in  (flags_in[0]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .y_out        (y_out),
        .zero_out     (zero_out),
        .negativo_out (negativo_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .clear_sticky (clear_sticky),
`ifdef ALU_CAPTURE_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .sticky_flags (sticky_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] y, input logic [3:0] f);
        in_valid = 1'b1;
        y_in     = y;
        flags_in = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Monitor: pops are checked against the queue; accepted pushes append the stimulus word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got %0h with empty scoreboard",
                             {y_out, zero_out, negativo_out, carry_out, overflow_out});
                end else begin
                    exp_entry = sb_q.pop_front();
                    if ({y_out, zero_out, negativo_out, carry_out, overflow_out} !== exp_entry) begin
                        failures++;
                        $display("FAIL pop_data: got %0h expected %0h",
                                 {y_out, zero_out, negativo_out, carry_out, overflow_out}, exp_entry);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({y_in, flags_in});
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        y_in         = '0;
        flags_in     = '0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", y_out, 0);
        check("rst_sticky", sticky_flags, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill, first-entry latency, refused fifth push, drain in order
        push_one(4'd1, 4'b0000);
        check("latency_out_valid", out_valid, 1);
        check("latency_y_out", y_out, 1);
        push_one(4'd2, 4'b0000);
        push_one(4'd3, 4'b0000);
        push_one(4'd4, 4'b0000);
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        check("fill_count", count, 4);
        in_valid = 1'b1;
        y_in     = 4'd5;
        tick();
        tick();
        in_valid = 1'b0;
        check("fifth_refused_count", count, 4);
        drain(5);
        check("drain_empty", empty, 1);
        check("drain_out_valid", out_valid, 0);
        check("drain_y_out_zero", y_out, 0);

        // Wrap: push/pop pairs at count 1
        push_one(4'd0, 4'b0000);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            y_in     = 4'(i);
            flags_in = 4'(i);
            tick();
            check("wrap_count", count, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("wrap_end_empty", empty, 1);

        // Full with simultaneous push and pop
        push_one(4'hA, 4'b0001);
        push_one(4'hB, 4'b0010);
        push_one(4'hC, 4'b0100);
        push_one(4'hD, 4'b1000);
        in_valid  = 1'b1;
        y_in      = 4'hE;
        flags_in  = 4'b0011;
        out_ready = 1'b1;
        check("full_pp_in_ready", in_ready, 0);
        tick();
        check("full_pp_count_after_pop", count, 3);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("full_pp_count_after_push", count, 4);
        drain(5);
        check("full_pp_empty", empty, 1);

        // Sticky accumulation, clear with push, pop leaves sticky alone
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check("sticky_cleared", sticky_flags, 4'b0000);
        push_one(4'd1, 4'b1000);
        push_one(4'd2, 4'b0010);
        check("sticky_accum", sticky_flags, 4'b1010);
        clear_sticky = 1'b1;
        push_one(4'd3, 4'b0100);
        clear_sticky = 1'b0;
        check("sticky_clear_with_push", sticky_flags, 4'b0100);
        drain(4);
        check("sticky_after_pop", sticky_flags, 4'b0100);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check("sticky_clear_alone", sticky_flags, 4'b0000);

`ifdef ALU_CAPTURE_DROP_CNT_EN
        push_one(4'd1, 4'b0000);
        push_one(4'd2, 4'b0000);
        push_one(4'd3, 4'b0000);
        push_one(4'd4, 4'b0000);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        in_valid = 1'b1;
        y_in     = 4'd9;
        tick();
        check("drop_first", drop_count, 1);
        repeat (299) tick();
        check("drop_saturated", drop_count, 255);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        in_valid = 1'b0;
        check("drop_cleared", drop_count, 0);
        drain(5);
`endif

        // Asynchronous reset mid-run discards entries
        push_one(4'd7, 4'b1111);
        push_one(4'd8, 4'b0101);
        check("pre_reset_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_y_out", y_out, 0);
        check("async_rst_sticky", sticky_flags, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push_one(4'd6, 4'b0010);
        drain(2);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
Downstream stage of the 4-bit ALU operation blocks, for example the circular-AND unit with outputs Y, zero, negativo, carry and overflow.
- Captures each ALU result word and its four flags into a small show-ahead FIFO, using valid/ready on both sides.
- Maintains sticky (accumulated) flags.
- Feeds the display/LED driver, which pops entries at its own pace.

Parameters:
- WIDTH, 4, ALU result width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  capture can accept; equals !full.
- y_in  in  WIDTH  ALU result Y.
- zero_in  in  1  ALU zero flag.
- negativo_in  in  1  ALU negative flag.
- carry_in  in  1  ALU carry flag.
- overflow_in  in  1  ALU overflow flag.
- out_valid  out  1  head entry available; equals !empty.
- out_ready  in  1  consumer pops the head entry.
- y_out  out  WIDTH  head entry result.
- zero_out  out  1  head entry zero flag.
- negativo_out  out  1  head entry negative flag.
- carry_out  out  1  head entry carry flag.
- overflow_out  out  1  head entry overflow flag.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- clear_sticky  in  1  synchronous clear of the sticky flags.
- sticky_flags  out  4  {zero, negativo, carry, overflow}, each the OR over all accepted entries since the last clear.

Behaviour:
- Reset (rst_n low, asynchronous):
  - read/write pointers and count = 0.
  - empty = 1, full = 0, in_ready = 1, out_valid = 0.
  - y_out and all flag outputs = 0.
  - sticky_flags = 0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all entries; there is no partial write.
- Push: in_valid && in_ready at a rising edge writes {y_in, flags} at the write pointer; the write pointer increments, wrapping at DEPTH.
- Pop: out_valid && out_ready at a rising edge advances the read pointer, wrapping at DEPTH.
- Show-ahead output: y_out and flag outputs always reflect the head entry while out_valid = 1.
  - When empty, they hold 0, not stale data.
- Latency: an entry pushed into an empty FIFO gives out_valid = 1 with its data in the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop:
  - When not empty and not full, both happen and count is unchanged.
  - When full, in_ready = 0, so only the pop occurs. There is no pass-through; in_ready does not depend on out_ready.
  - When empty, only the push occurs.
- in_ready and out_valid are functions of registered state only, with no combinational path from in_valid or out_ready.
- Producer rule: y_in and flags must be held stable while in_valid && !in_ready. The block does not check this.
- Sticky flags:
  - On an accepted push: sticky <= sticky | flags_in.
  - clear_sticky with no push: sticky <= 0.
  - clear_sticky together with a push: sticky <= flags_in of that push; the new entry wins.
  - Popping never changes sticky.
- count is updated as +1 on push only, -1 on pop only, otherwise unchanged. It never exceeds DEPTH and never underflows.

Optional Feature:
ALU_CAPTURE_DROP_CNT_EN
- With the macro: adds output drop_count [7:0]. It increments by 1 on each cycle with in_valid && !in_ready, saturates at 255, is reset to 0 by rst_n, and is also cleared by clear_sticky; clear wins over increment.
- Without the macro: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_flags_t, a packed struct {zero, negativo, carry, overflow}.
  - typedef alu_entry_t, a packed struct {y [WIDTH-1:0], alu_flags_t flags}.
  - constant ALU_WIDTH = 4.
  - Reused by all ALU operation blocks.
- One sub-module, alu_capture_fifo_mem: DEPTH x entry register array with a synchronous write port and an asynchronous read port.
- The top level holds pointers, count, handshake and sticky logic.

Test Plan:
- Reset: assert rst_n = 0 mid-run after pushing 2 entries -> count = 0, empty = 1, in_ready = 1, out_valid = 0, y_out = 0, sticky_flags = 0 immediately (asynchronous).
- Fill: push Y = 1, 2, 3, 4 with flags 0000 and out_ready = 0.
  - Expect full = 1, in_ready = 0.
  - A fifth push of Y = 5 is not accepted.
  - Draining gives 1, 2, 3, 4 in order, then empty = 1.
- Wrap: 10 push/pop pairs with Y = 0..9 at count = 1 -> output order 0..9 and count stays 1 throughout.
- Full with simultaneous push and pop: count = 4, in_valid = 1, out_ready = 1 -> only the pop occurs and count = 3; the push is accepted on the next cycle.
- Sticky: push flags Z = 1 (1000), then C = 1 (0010) -> sticky = 1010. Then clear_sticky with a push of N = 1 (0100) -> sticky = 0100.
- With ALU_CAPTURE_DROP_CNT_EN: hold in_valid = 1 for 300 cycles with FIFO full and out_ready = 0 -> drop_count = 255 (saturated); clear_sticky -> 0.
